// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: each accepted word goes out as a SYNC_WORD preamble
// and then DATA_W payload bits, MSB first, followed by at least GAP_LEN+1 idle bits.
module sync_frame_tx #(
   parameter int                  SYNC_LEN  = 5,
   parameter logic [SYNC_LEN-1:0] SYNC_WORD = 5'b10110,
   parameter int                  DATA_W    = 8,
   parameter int                  GAP_LEN   = 0,
   parameter logic                IDLE_BIT  = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              tx,
   output logic              tx_active,
   output logic              frame_done,
   output logic [1:0]        fsm_state
);

   localparam int FW   = SYNC_LEN + DATA_W;
   localparam int MAXA = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
   localparam int MAXC = (MAXA > GAP_LEN) ? MAXA : GAP_LEN;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [FW-1:0]   frame_sr, frame_sr_nxt;
   logic [FW-1:0]   load_word;
   logic            tx_nxt, tx_active_nxt, data_ready_nxt, frame_done_nxt;

   // Handshake: a word is taken on a rising edge where data_valid and the
   // registered data_ready are both high; data_ready is high only in IDLE and
   // drops on the accepting edge, so at most one word is taken per frame.
   assign load_word = {SYNC_WORD, data_in};
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         frame_sr   <= '0;
         tx         <= IDLE_BIT;
         tx_active  <= 1'b0;
         data_ready <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         frame_sr   <= frame_sr_nxt;
         tx         <= tx_nxt;
         tx_active  <= tx_active_nxt;
         data_ready <= data_ready_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   // Preamble and payload share one shift register; the counter alone tells
   // which phase the outgoing bit belongs to.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      frame_sr_nxt   = frame_sr;
      tx_nxt         = tx;
      tx_active_nxt  = tx_active;
      data_ready_nxt = data_ready;
      frame_done_nxt = 1'b0;

      case (state)
         ST_IDLE: begin
            tx_nxt         = IDLE_BIT;
            tx_active_nxt  = 1'b0;
            data_ready_nxt = 1'b1;
            if (data_valid && data_ready) begin
               tx_nxt         = load_word[FW-1];
               frame_sr_nxt   = load_word << 1;
               tx_active_nxt  = 1'b1;
               data_ready_nxt = 1'b0;
               cnt_nxt        = SYNC_LAST;
               state_nxt      = ST_SYNC;
            end
         end

         ST_SYNC: begin
            tx_nxt       = frame_sr[FW-1];
            frame_sr_nxt = frame_sr << 1;
            if (cnt == '0) begin
               cnt_nxt        = DATA_LAST;
               frame_done_nxt = (DATA_W == 1);
               state_nxt      = ST_DATA;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end

         ST_DATA: begin
            if (cnt == '0) begin
               tx_nxt        = IDLE_BIT;
               tx_active_nxt = 1'b0;
               frame_sr_nxt  = '0;
               if (GAP_LEN > 0) begin
                  cnt_nxt   = GAP_LAST;
                  state_nxt = ST_GAP;
               end else begin
                  data_ready_nxt = 1'b1;
                  state_nxt      = ST_IDLE;
               end
            end else begin
               tx_nxt         = frame_sr[FW-1];
               frame_sr_nxt   = frame_sr << 1;
               frame_done_nxt = (cnt == CW'(1));
               cnt_nxt        = cnt - CW'(1);
            end
         end

         ST_GAP: begin
            tx_nxt        = IDLE_BIT;
            tx_active_nxt = 1'b0;
            if (cnt == '0) begin
               data_ready_nxt = 1'b1;
               state_nxt      = ST_IDLE;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end

         default: begin
            tx_nxt         = IDLE_BIT;
            tx_active_nxt  = 1'b0;
            data_ready_nxt = 1'b0;
            cnt_nxt        = '0;
            state_nxt      = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: a frame-level model checked every cycle, plus directed
// frames, back-to-back spacing, a loopback 10110 detector and mid-frame reset.
module tb_sync_frame_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;

   logic       data_ready_d, tx_d, tx_active_d, frame_done_d;
   logic [1:0] state_d;
   logic       data_ready_g, tx_g, tx_active_g, frame_done_g;
   logic [1:0] state_g;

   int checks = 0;
   int errors = 0;

   sync_frame_tx u_dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready_d), .tx(tx_d), .tx_active(tx_active_d),
      .frame_done(frame_done_d), .fsm_state(state_d)
   );

   sync_frame_tx #(.GAP_LEN(3)) u_gap (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready_g), .tx(tx_g), .tx_active(tx_active_g),
      .frame_done(frame_done_g), .fsm_state(state_g)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- frame-level model (default parameters) ----------------
   typedef struct packed {
      logic tx;
      logic act;
      logic done;
      logic rdy;
   } rec_t;

   rec_t exp_q[$];
   rec_t cur = '0;

   function automatic rec_t mk(input logic t, input logic a, input logic d, input logic r);
      rec_t x;
      x.tx = t; x.act = a; x.done = d; x.rdy = r;
      return x;
   endfunction

   // One record per output cycle: 13 frame bits, then the queue runs dry and
   // the line idles with data_ready high.
   function automatic void build_frame(input logic [7:0] w);
      logic [12:0] bits;
      bits = {5'b10110, w};
      for (int i = 12; i >= 0; i--) exp_q.push_back(mk(bits[i], 1'b1, (i == 0), 1'b0));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         cur = mk(1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
         if (cur.rdy && data_valid) build_frame(data_in);
         if (exp_q.size() > 0) cur = exp_q.pop_front();
         else cur = mk(1'b0, 1'b0, 1'b0, 1'b1);
      end
   end

   always @(negedge clk) begin
      chk("model_tx", 16'(tx_d), 16'(cur.tx));
      chk("model_active", 16'(tx_active_d), 16'(cur.act));
      chk("model_done", 16'(frame_done_d), 16'(cur.done));
      chk("model_ready", 16'(data_ready_d), 16'(cur.rdy));
   end

   // ---------------- loopback 10110 Moore detector and monitors ----------------
   logic [4:0] hist;
   logic       det_z;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) hist <= 5'b0;
      else        hist <= {hist[3:0], tx_d};
   end
   assign det_z = (hist == 5'b10110);

   int   pos = 0;
   int   z_cnt = 0;
   int   done_cnt = 0;
   int   idle_d = 0;
   int   idle_g = 0;
   int   runs_d[$];
   int   runs_g[$];
   logic prev_act_d = 1'b0;
   logic prev_act_g = 1'b0;

   always @(negedge clk) begin
      if (tx_active_d) pos = prev_act_d ? pos + 1 : 1;
      else             pos = 0;
      if (det_z) begin
         z_cnt++;
         chk("z_timing", 16'(pos), 16'd6);
      end
      if (frame_done_d) done_cnt++;
      if (tx_active_d && !prev_act_d) runs_d.push_back(idle_d);
      idle_d = tx_active_d ? 0 : idle_d + 1;
      if (tx_active_g && !prev_act_g) runs_g.push_back(idle_g);
      idle_g = tx_active_g ? 0 : idle_g + 1;
      prev_act_d = tx_active_d;
      prev_act_g = tx_active_g;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (data_ready_d) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("ready_timeout", 16'd0, 16'd1);
   endtask

   // Sends one word with a one-cycle valid, toggles data_in during the frame,
   // and returns the 13 captured tx bits and the frame_done cycle.
   task automatic send_capture(input logic [7:0] w, output logic [12:0] bits, output int done_pos);
      bit ok;
      bits = '0;
      done_pos = 0;
      wait_ready(ok);
      data_in = w;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      for (int i = 0; i < 13; i++) begin
         if (i > 0) @(negedge clk);
         bits[12-i] = tx_d;
         chk("frame_active", 16'(tx_active_d), 16'd1);
         if (frame_done_d) done_pos = i + 1;
         data_in = ~data_in;
      end
      @(negedge clk);
      chk("after_active", 16'(tx_active_d), 16'd0);
      chk("after_ready", 16'(data_ready_d), 16'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [12:0] bits;
      int          dp;
      int          dc;
      bit          ok;

      // Reset state
      #2;
      chk("rst_tx", 16'(tx_d), 16'd0);
      chk("rst_active", 16'(tx_active_d), 16'd0);
      chk("rst_ready", 16'(data_ready_d), 16'd0);
      chk("rst_done", 16'(frame_done_d), 16'd0);
      chk("rst_tx_gap", 16'(tx_g), 16'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_release", 16'(data_ready_d), 16'd1);

      // Idle line with no valid
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_tx", 16'(tx_d), 16'd0);
         chk("idle_active", 16'(tx_active_d), 16'd0);
      end

      // Single frame A5 with data_in toggling in flight
      send_capture(8'hA5, bits, dp);
      chk("a5_bits", 16'(bits), 16'(13'b1011010100101));
      chk("a5_done_pos", 16'(dp), 16'd13);
      repeat (6) @(negedge clk);

      // Back-to-back: FF then 00 with valid held high
      runs_d.delete();
      runs_g.delete();
      data_in = 8'hFF;
      data_valid = 1'b1;
      wait_ready(ok);
      @(negedge clk);
      data_in = 8'h00;
      repeat (45) @(negedge clk);
      data_valid = 1'b0;
      repeat (20) @(negedge clk);
      chk("b2b_runs_d", 16'(runs_d.size() >= 4), 16'd1);
      if (runs_d.size() >= 4) begin
         chk("b2b_gap0_a", 16'(runs_d[1]), 16'd1);
         chk("b2b_gap0_b", 16'(runs_d[2]), 16'd1);
         chk("b2b_gap0_c", 16'(runs_d[3]), 16'd1);
      end
      chk("b2b_runs_g", 16'(runs_g.size() >= 3), 16'd1);
      if (runs_g.size() >= 3) begin
         chk("b2b_gap3_a", 16'(runs_g[1]), 16'd4);
         chk("b2b_gap3_b", 16'(runs_g[2]), 16'd4);
      end

      // Loopback: three 00 frames, one detector pulse each
      z_cnt = 0;
      for (int f = 0; f < 3; f++) begin
         send_capture(8'h00, bits, dp);
         chk("zero_bits", 16'(bits), 16'(13'b1011000000000));
      end
      repeat (4) @(negedge clk);
      chk("z_count", 16'(z_cnt), 16'd3);

      // Reset during payload bit 3
      wait_ready(ok);
      data_in = 8'hFF;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (7) @(negedge clk);
      chk("mid_tx", 16'(tx_d), 16'd1);
      chk("mid_active", 16'(tx_active_d), 16'd1);
      dc = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_tx", 16'(tx_d), 16'd0);
      chk("abort_active", 16'(tx_active_d), 16'd0);
      chk("abort_done", 16'(frame_done_d), 16'd0);
      chk("abort_ready", 16'(data_ready_d), 16'd0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      send_capture(8'h3C, bits, dp);
      chk("3c_bits", 16'(bits), 16'(13'b1011000111100));
      chk("3c_done_pos", 16'(dp), 16'd13);
      chk("abort_no_done", 16'(done_cnt), 16'(dc + 1));

      // Long idle with data_valid low
      data_in = 8'h5A;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         chk("final_idle_tx", 16'(tx_d), 16'd0);
         chk("final_idle_active", 16'(tx_active_d), 16'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog at %0t: got timeout expected completion", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
